// File: rtl/mem_ctrl_mp.sv
// Multi-port memory controller: round-robin arbitration of NPORTS requesters onto one
// word-organised RAM with byte-enabled writes, programmable wait states and per-port done/err.
module mem_ctrl_mp #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned NPORTS = 2,
    parameter int unsigned WAIT   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          req,
    input  logic [NPORTS-1:0]          rw,
    input  logic [NPORTS*AWIDTH-1:0]   addr,
    input  logic [NPORTS*DWIDTH-1:0]   wdata,
    input  logic [NPORTS*DWIDTH/8-1:0] be,
    output logic [NPORTS-1:0]          gnt,
    output logic [NPORTS-1:0]          done,
    output logic                       err,
    output logic [DWIDTH-1:0]          rdata
);

    localparam int unsigned NB   = DWIDTH / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned CW   = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [AWIDTH-1:0] OFFMASK = AWIDTH'((1 << OFFW) - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       last_q, last_d;
    logic                rw_q, rw_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic [NPORTS-1:0]   gnt_q, gnt_d;
    logic [NPORTS-1:0]   done_q, done_d;
    logic                err_q, err_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;

    logic [DWIDTH-1:0]   mem [DEPTH];

    logic                found;
    logic [PW-1:0]       pick;
    logic [AWIDTH-1:0]   word;
    logic [IW-1:0]       widx;
    logic                legal;
    logic                commit;
    logic                wr_en;

    // Rotating priority: first requester after the last one served.
    always_comb begin
        int unsigned c;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 1; i <= NPORTS; i++) begin
            c = (32'(last_q) + i) % NPORTS;
            if (!found && req[c[PW-1:0]]) begin
                found = 1'b1;
                pick  = c[PW-1:0];
            end
        end
    end

    assign word   = addr_q >> OFFW;
    assign widx   = IW'(word);
    assign legal  = ((addr_q & OFFMASK) == '0) && (64'(word) < 64'(DEPTH));
    assign commit = (state_q == StBusy) && (cnt_q == '0);
    assign wr_en  = commit && !rw_q && legal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    idx_d   = pick;
                    rw_d    = rw[pick];
                    addr_d  = addr[32'(pick) * AWIDTH +: AWIDTH];
                    wdata_d = wdata[32'(pick) * DWIDTH +: DWIDTH];
                    be_d    = be[32'(pick) * NB +: NB];
                    gnt_d   = NPORTS'(1) << pick;
                    cnt_d   = CW'(WAIT);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    done_d  = NPORTS'(1) << idx_q;
                    err_d   = !legal;
                    state_d = StDone;
                    if (!legal) begin
                        rdata_d = '0;
                    end else if (rw_q) begin
                        rdata_d = mem[widx];
                    end
                end
            end
            StDone: begin
                gnt_d   = '0;
                err_d   = 1'b0;
                last_d  = idx_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= PW'(NPORTS - 1);
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately outside the reset domain; reset forces StIdle so no write lands.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be_q[k]) begin
                    mem[widx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Directed bench for mem_ctrl_mp: a WAIT=1 instance for the main sequence and a WAIT=0
// instance for the short-latency build.
module tb_mem_ctrl_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  req = '0, rw = '0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;
    logic [1:0]  gnt, done;
    logic        err;
    logic [31:0] rdata;

    logic [1:0]  req2 = '0, rw2 = '0;
    logic [31:0] addr2 = '0;
    logic [63:0] wdata2 = '0;
    logic [7:0]  be2 = '0;
    logic [1:0]  gnt2, done2;
    logic        err2;
    logic [31:0] rdata2;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mem_ctrl_mp #(.DWIDTH(32), .AWIDTH(16), .DEPTH(1024), .NPORTS(2), .WAIT(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata)
    );

    mem_ctrl_mp #(.DWIDTH(32), .AWIDTH(16), .DEPTH(1024), .NPORTS(2), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req2), .rw(rw2), .addr(addr2), .wdata(wdata2), .be(be2),
        .gnt(gnt2), .done(done2), .err(err2), .rdata(rdata2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT=1 instance, started from IDLE; returns in IDLE.
    task automatic txn(input string tag, input int p, input logic r, input logic [15:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       input logic e_err, input logic [31:0] e_rdata);
        int n;
        rw[p] = r;
        addr[p*16 +: 16] = a;
        wdata[p*32 +: 32] = wd;
        be[p*4 +: 4] = b;
        req[p] = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                n = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_done"}, 32'(done), 32'(2'b01 << p));
        check({tag, "_gnt"}, 32'(gnt), 32'(2'b01 << p));
        check({tag, "_err"}, 32'(err), 32'(e_err));
        check({tag, "_rdata"}, rdata, e_rdata);
        req[p] = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
    endtask

    task automatic wait_done2(output int n);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done2 != 2'b00) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int ndone;
        int last_cyc;
        int port;
        int n;

        // Reset state
        @(posedge clk); #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Basic write/read
        txn("wr0", 0, 1'b0, 16'd0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        txn("rd0", 0, 1'b1, 16'd0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

        // Byte enables on port 1
        txn("wr4", 1, 1'b0, 16'd4, 32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF);
        txn("wr4be", 1, 1'b0, 16'd4, 32'hAABBCCDD, 4'b0101, 1'b0, 32'hDEADBEEF);
        txn("rd4", 1, 1'b1, 16'd4, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);

        // Illegal accesses
        txn("rd_mis", 0, 1'b1, 16'd2, 32'h0, 4'hF, 1'b1, 32'h0);
        txn("wr_oor", 1, 1'b0, 16'd4096, 32'h55555555, 4'hF, 1'b1, 32'h0);
        txn("rd0b", 0, 1'b1, 16'd0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

        // Contention after reset: port 0 first, strict alternation, 4 cycles apart
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rw = 2'b00;
        addr = {16'd20, 16'd16};
        wdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
        be = 8'hFF;
        req = 2'b11;
        ndone = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 40 && ndone < 4; cyc++) begin
            @(posedge clk); #1;
            check("cont_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (done != 2'b00) begin
                check("cont_done_onehot", 32'($onehot(done)), 32'd1);
                port = (done == 2'b10) ? 1 : 0;
                check("cont_order", 32'(port), 32'(ndone % 2));
                if (ndone == 0) check("cont_first", 32'(cyc), 32'd3);
                else check("cont_spacing", 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
                ndone++;
                if (ndone == 4) req = 2'b00;
            end
        end
        check("cont_count", 32'(ndone), 32'd4);
        @(posedge clk); #1;
        txn("rd16", 0, 1'b1, 16'd16, 32'h0, 4'h0, 1'b0, 32'hA0A0A0A0);
        txn("rd20", 1, 1'b1, 16'd20, 32'h0, 4'h0, 1'b0, 32'hB1B1B1B1);

        // Reset in BUSY aborts the write
        txn("wr8", 0, 1'b0, 16'd8, 32'hCAFEF00D, 4'hF, 1'b0, 32'hB1B1B1B1);
        rw[0] = 1'b0;
        addr[15:0] = 16'd8;
        wdata[31:0] = 32'h12345678;
        be[3:0] = 4'hF;
        req[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_busy_gnt", 32'(gnt), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        req = 2'b00;
        txn("rd8", 0, 1'b1, 16'd8, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);

        // WAIT=0 instance: done one cycle after the sampling edge
        rw2 = 2'b00;
        addr2[15:0] = 16'd12;
        wdata2[31:0] = 32'h0BADC0DE;
        be2 = 8'hFF;
        req2 = 2'b01;
        wait_done2(n);
        check("w0_wr_latency", 32'(n), 32'd2);
        check("w0_wr_gnt", 32'(gnt2), 32'd1);
        req2 = 2'b00;
        @(posedge clk); #1;
        check("w0_wr_idle", 32'(done2), 32'd0);
        rw2 = 2'b01;
        req2 = 2'b01;
        wait_done2(n);
        check("w0_rd_latency", 32'(n), 32'd2);
        check("w0_rd_err", 32'(err2), 32'd0);
        check("w0_rd_rdata", rdata2, 32'h0BADC0DE);
        req2 = 2'b00;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_mp.md
# mem_ctrl_mp

Parametrised multi-port memory controller: the next generation of the single-requester controller. It arbitrates NPORTS independent requesters round-robin onto one synchronous word-organised memory of DEPTH words. It adds byte-enabled writes, programmable wait states, per-port done/error signalling, and separate read/write data paths (no tristate bus). It sits between the CPU-side masters (fetch, load/store, debug) and on-chip RAM.

## Interface
Parameters:
- DWIDTH, 32, data word width; must be a multiple of 8.
- AWIDTH, 16, byte-address width per port.
- DEPTH, 1024, memory depth in words.
- NPORTS, 2, number of requesters (≥1).
- WAIT, 1, extra wait cycles before each access commits (≥0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  NPORTS  per-port request; held high until that port's done.
- rw  in  NPORTS  per-port direction: 1 = read, 0 = write.
- addr  in  NPORTS*AWIDTH  per-port byte address; port i occupies bits [i*AWIDTH +: AWIDTH].
- wdata  in  NPORTS*DWIDTH  per-port write data.
- be  in  NPORTS*DWIDTH/8  per-port byte enables; bit k enables byte k.
- gnt  out  NPORTS  one-hot grant; the winner is high from the BUSY entry until the end of DONE.
- done  out  NPORTS  one-cycle completion pulse to the granted port.
- err  out  1  high with done when the access was rejected.
- rdata  out  DWIDTH  read result; valid while done is high, held until the next DONE.

## Operation
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - If any req is high, pick the first requesting port scanning last+1, last+2, … modulo NPORTS.
  - Latch that index plus its rw/addr/wdata/be. Set gnt[idx]; load cnt = WAIT; go to BUSY.
  - If no req is high, stay in IDLE.
- BUSY:
  - If cnt ≠ 0, decrement cnt and stay in BUSY.
  - If cnt = 0, perform the access and go to DONE.
- Access:
  - Word index = addr >> log2(DWIDTH/8).
  - The access is illegal if any low byte-offset bit is set or the word index ≥ DEPTH. An illegal access modifies nothing, sets err = 1 and rdata = 0.
  - Legal write: each byte with be[k] = 1 is written; other bytes are unchanged. be = 0 is a legal no-op.
  - Legal read: rdata is loaded with the stored word, ignoring be. A write leaves rdata unchanged.
- DONE:
  - done[idx] = 1 for exactly one cycle; err stays valid alongside it.
  - last is updated to idx. Go to IDLE, where gnt, done and err clear.
- Requesters must hold inputs stable from req rise until done. A requester may deassert req in the cycle after done without being re-served.
- Reset:
  - Aborts any transaction; an in-flight write is not committed.
  - FSM goes to IDLE; gnt = 0, done = 0, err = 0, rdata = 0, cnt = 0.
  - last = NPORTS-1, so port 0 wins first.
  - Memory array contents are not cleared.

## Timing
- Request sampled at IDLE edge E0: BUSY for WAIT+1 cycles, access committed at edge E0+WAIT+1, done high during cycle E0+WAIT+1 … E0+WAIT+2.
- Occupancy is WAIT+3 cycles per transaction (IDLE, BUSY×(WAIT+1), DONE).
- Back-to-back service under continuous contention strictly alternates among requesting ports; no port waits more than NPORTS-1 transactions.
- A req arriving during BUSY/DONE is first considered at the next IDLE edge.
- Write-then-read to the same word from any port returns the new data; there is no forwarding hazard because transactions are serialised.
- Asserting reset asynchronously clears outputs immediately. Deasserting it returns to IDLE on the next edge.

## Test plan
- Reset, WAIT=1: port0 writes 0xDEADBEEF to addr 0 with be=0xF, then reads addr 0. Required: done 2 cycles after each sampled req, err=0, rdata=0xDEADBEEF.
- Byte enables: write 0x11223344 to addr 4 (be=0xF), then 0xAABBCCDD with be=0b0101. Read of addr 4 returns 0x11BB33DD.
- Contention, NPORTS=2: both ports hold req continuously after reset, each writing a distinct address. Required: grant order is 0,1,0,1, one transaction per 4 cycles, gnt always one-hot.
- Errors: read addr 2 (misaligned) and write addr DEPTH*4 (out of range). Required: err=1 with done, rdata=0, and a subsequent read of addr 0 is unchanged.
- Reset mid-op: write 0x12345678 to addr 8 (holding 0xCAFEF00D); assert reset during BUSY. Required: all outputs 0 immediately, and a later read of addr 8 returns 0xCAFEF00D.
- WAIT=0 build: single read. Required: done 1 cycle after the sampled edge (3-cycle occupancy).
